pipeline_hazard_ctrl: RTL and testbench

//  Sequences the four interstage registers (if_id, id_ex, ex_mem, mem_wb) of the 5-stage core.

---
 rtl/pipeline_ctrl_pkg.sv | 20 ++
 rtl/pipeline_hazard_ctrl_if.sv | 27 ++
 rtl/forwarding_unit.sv | 18 +
 rtl/pipeline_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Owns the FSM state encoding and the forwarding-select codes with their selection rule.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {StRun, StBubble, StMemWait} ctrl_state_e;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // MEM result is younger than WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] mem_rd, input logic mem_wr,
                                           input logic [4:0] wb_rd,  input logic wb_wr);
        if (mem_wr && (mem_rd != 5'd0) && (mem_rd == rs)) return FWD_MEM;
        if (wb_wr && (wb_rd != 5'd0) && (wb_rd == rs))    return FWD_WB;
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard/control bundle between the datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic             ex_memRead, mem_regWrite, wb_regWrite;
    logic             branch_taken, mem_req, mem_ready;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush, pc_sel;
    logic [1:0]       fwdA, fwdB;
    logic [CNT_W-1:0] stall_cycles;
    logic             mem_err;

    modport master (
        output id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd,
        output ex_memRead, mem_regWrite, wb_regWrite, branch_taken, mem_req, mem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, pc_sel,
        input  fwdA, fwdB, stall_cycles, mem_err
    );

    modport slave (
        input  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd,
        input  ex_memRead, mem_regWrite, wb_regWrite, branch_taken, mem_req, mem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, pc_sel,
        output fwdA, fwdB, stall_cycles, mem_err
    );
endinterface

// File: rtl/forwarding_unit.sv
// EX-stage operand forwarding selects; purely combinational.
module forwarding_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs_i,
    input  logic [4:0] ex_rt_i,
    input  logic [4:0] mem_rd_i,
    input  logic       mem_regwrite_i,
    input  logic [4:0] wb_rd_i,
    input  logic       wb_regwrite_i,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o
);
    always_comb begin
        fwd_a_o = fwd_sel(ex_rs_i, mem_rd_i, mem_regwrite_i, wb_rd_i, wb_regwrite_i);
        fwd_b_o = fwd_sel(ex_rt_i, mem_rd_i, mem_regwrite_i, wb_rd_i, wb_regwrite_i);
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Interstage register sequencing for the 5-stage core: load-use bubbles, branch flushes,
// data-memory waits with timeout, forwarding selects and a stall-cycle counter.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input logic                   clock,
    input logic                   reset,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int unsigned      WaitW   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

    ctrl_state_e      state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             err_q, err_d;
    logic [4:0]       en;  // {pc, ifid, idex, exmem, memwb}
    logic             ifid_flush, idex_flush, pc_sel, mem_hold, load_use;
    logic [1:0]       fwd_a, fwd_b;

    forwarding_unit u_fwd (
        .ex_rs_i        (bus.ex_rs),
        .ex_rt_i        (bus.ex_rt),
        .mem_rd_i       (bus.mem_rd),
        .mem_regwrite_i (bus.mem_regWrite),
        .wb_rd_i        (bus.wb_rd),
        .wb_regwrite_i  (bus.wb_regWrite),
        .fwd_a_o        (fwd_a),
        .fwd_b_o        (fwd_b)
    );

    always_comb begin
        mem_hold = bus.mem_req && !bus.mem_ready;
        load_use = bus.ex_memRead && (bus.ex_rd != 5'd0) &&
                   ((bus.ex_rd == bus.id_rs) || (bus.ex_rd == bus.id_rt));
        state_d    = state_q;
        wait_d     = wait_q;
        err_d      = err_q;
        en         = 5'b11111;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        pc_sel     = 1'b0;
        case (state_q)
            StMemWait: begin
                // Exit cycle advances everything; branch/load-use are re-seen next cycle.
                if (bus.mem_ready) begin
                    state_d = StRun;
                    wait_d  = '0;
                end else if (wait_q == WaitMax) begin
                    err_d   = 1'b1;
                    state_d = StRun;
                    wait_d  = '0;
                end else begin
                    en     = 5'b00000;
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StRun, StBubble: begin
                state_d = StRun;
                if (mem_hold) begin
                    en      = 5'b00000;
                    state_d = StMemWait;
                    wait_d  = WaitW'(1);
                end else if (bus.branch_taken) begin
                    pc_sel     = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use && (state_q == StRun)) begin
                    en         = 5'b00111;
                    idex_flush = 1'b1;
                    state_d    = StBubble;
                end
            end
            default: state_d = StRun;
        endcase
        if (reset) begin
            en         = 5'b00000;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            pc_sel     = 1'b0;
        end
        stall_d = stall_q;
        if (!en[4] && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StRun;
            wait_q  <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign bus.pc_en        = en[4];
    assign bus.ifid_en      = en[3];
    assign bus.idex_en      = en[2];
    assign bus.exmem_en     = en[1];
    assign bus.memwb_en     = en[0];
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_flush   = idex_flush;
    assign bus.pc_sel       = pc_sel;
    assign bus.fwdA         = reset ? FWD_NONE : fwd_a;
    assign bus.fwdB         = reset ? FWD_NONE : fwd_b;
    assign bus.stall_cycles = stall_q;
    assign bus.mem_err      = err_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios followed by random
// traffic, all compared each cycle against a behavioural model of the control rules.
module tb_pipeline_hazard_ctrl;
    localparam int unsigned MEM_TIMEOUT = 6;
    localparam int unsigned CNT_W       = 5;
    localparam int          STALL_MAX   = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    // Model: waiting on memory, cycles already waited, bubble just inserted, counters.
    bit m_wait = 0;
    int m_waited = 0;
    bit m_bubbled = 0;
    int m_stalls = 0;
    bit m_err = 0;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_fwd(int rs, int mrd, bit mwr, int wrd, bit wwr);
        if (mwr && mrd != 0 && mrd == rs) return 2;
        if (wwr && wrd != 0 && wrd == rs) return 1;
        return 0;
    endfunction

    task automatic clear_inputs();
        {bus.id_rs, bus.id_rt, bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.mem_rd, bus.wb_rd} = '0;
        {bus.ex_memRead, bus.mem_regWrite, bus.wb_regWrite} = '0;
        {bus.branch_taken, bus.mem_req, bus.mem_ready} = '0;
    endtask

    task automatic rand_inputs();
        bus.id_rs = 5'($urandom_range(0, 3));
        bus.id_rt = 5'($urandom_range(0, 3));
        bus.ex_rs = 5'($urandom_range(0, 3));
        bus.ex_rt = 5'($urandom_range(0, 3));
        bus.ex_rd = 5'($urandom_range(0, 3));
        bus.mem_rd = 5'($urandom_range(0, 3));
        bus.wb_rd = 5'($urandom_range(0, 3));
        bus.ex_memRead   = ($urandom_range(0, 1) == 1);
        bus.mem_regWrite = ($urandom_range(0, 1) == 1);
        bus.wb_regWrite  = ($urandom_range(0, 1) == 1);
        bus.branch_taken = ($urandom_range(0, 4) == 0);
        bus.mem_req      = ($urandom_range(0, 2) == 0);
        bus.mem_ready    = ($urandom_range(0, 1) == 1);
        reset            = ($urandom_range(0, 99) == 0);
    endtask

    // Checks every output at the falling edge, then advances the model at the rising edge.
    task automatic cycle();
        bit       lu, hold, took_bubble;
        bit [4:0] e_en;
        bit       e_iff, e_xff, e_sel;
        int       e_fa, e_fb;
        @(negedge clock);
        lu   = bus.ex_memRead && bus.ex_rd != 0 &&
               (bus.ex_rd == bus.id_rs || bus.ex_rd == bus.id_rt);
        hold = bus.mem_req && !bus.mem_ready;
        e_en = 5'b11111; e_iff = 0; e_xff = 0; e_sel = 0; took_bubble = 0;
        if (reset) begin
            e_en = 5'b00000; e_iff = 1; e_xff = 1;
        end else if (m_wait) begin
            if (!bus.mem_ready && m_waited < MEM_TIMEOUT) e_en = 5'b00000;
        end else if (hold) begin
            e_en = 5'b00000;
        end else if (bus.branch_taken) begin
            e_sel = 1; e_iff = 1; e_xff = 1;
        end else if (lu && !m_bubbled) begin
            e_en = 5'b00111; e_xff = 1; took_bubble = 1;
        end
        e_fa = reset ? 0 : exp_fwd(bus.ex_rs, bus.mem_rd, bus.mem_regWrite, bus.wb_rd,
                                   bus.wb_regWrite);
        e_fb = reset ? 0 : exp_fwd(bus.ex_rt, bus.mem_rd, bus.mem_regWrite, bus.wb_rd,
                                   bus.wb_regWrite);
        chk("enables", {27'd0, bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en,
                        bus.memwb_en}, {27'd0, e_en});
        chk("ifid_flush", {31'd0, bus.ifid_flush}, {31'd0, e_iff});
        chk("idex_flush", {31'd0, bus.idex_flush}, {31'd0, e_xff});
        chk("pc_sel", {31'd0, bus.pc_sel}, {31'd0, e_sel});
        chk("fwdA", {30'd0, bus.fwdA}, e_fa);
        chk("fwdB", {30'd0, bus.fwdB}, e_fb);
        chk("stall_cycles", {27'd0, bus.stall_cycles}, m_stalls);
        chk("mem_err", {31'd0, bus.mem_err}, {31'd0, m_err});
        @(posedge clock);
        if (reset) begin
            m_wait = 0; m_waited = 0; m_bubbled = 0; m_stalls = 0; m_err = 0;
        end else begin
            if (!e_en[4] && m_stalls < STALL_MAX) m_stalls++;
            m_bubbled = took_bubble;
            if (m_wait) begin
                if (bus.mem_ready) m_wait = 0;
                else if (m_waited >= MEM_TIMEOUT) begin m_err = 1; m_wait = 0; end
                else m_waited++;
            end else if (hold) begin
                m_wait = 1; m_waited = 1;
            end
        end
        #1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        cycle();
        // Reset forces bubbles and blocks branch/memory effects.
        bus.branch_taken = 1; bus.mem_req = 1;
        bus.ex_rs = 3; bus.mem_rd = 3; bus.mem_regWrite = 1;
        cycle();
        clear_inputs();
        reset = 1'b0;

        // lw r2 feeding ID: one bubble, then advance, then a fresh RUN re-detects.
        bus.ex_memRead = 1; bus.ex_rd = 2; bus.id_rs = 2;
        #1;
        chk("lu_pc_en", {31'd0, bus.pc_en}, 0);
        chk("lu_idex_flush", {31'd0, bus.idex_flush}, 1);
        cycle();
        #1;
        chk("lu_next_pc_en", {31'd0, bus.pc_en}, 1);
        cycle();
        cycle();
        cycle();

        // lw r0 never stalls; MEM beats WB for forwarding.
        clear_inputs();
        bus.ex_memRead = 1; bus.ex_rd = 0; bus.id_rs = 0; bus.ex_rs = 3;
        bus.mem_rd = 3; bus.mem_regWrite = 1; bus.wb_rd = 3; bus.wb_regWrite = 1;
        #1;
        chk("lw_r0_pc_en", {31'd0, bus.pc_en}, 1);
        chk("fwdA_mem", {30'd0, bus.fwdA}, 2);
        cycle();
        bus.mem_regWrite = 0;
        cycle();
        bus.ex_rt = 3; bus.wb_rd = 7;
        cycle();

        // Taken branch in RUN.
        clear_inputs();
        bus.branch_taken = 1;
        #1;
        chk("br_pc_sel", {31'd0, bus.pc_sel}, 1);
        chk("br_ifid_flush", {31'd0, bus.ifid_flush}, 1);
        cycle();

        // Five-cycle memory wait with a branch deferred until after exit.
        clear_inputs();
        reset = 1;
        cycle();
        reset = 0;
        bus.mem_req = 1; bus.branch_taken = 1;
        repeat (5) cycle();
        chk("stall_5", {27'd0, bus.stall_cycles}, 5);
        bus.mem_ready = 1;
        cycle();
        bus.mem_req = 0; bus.mem_ready = 0;
        #1;
        chk("deferred_branch", {31'd0, bus.pc_sel}, 1);
        cycle();

        // Timeout: memory never ready.
        clear_inputs();
        bus.mem_req = 1;
        repeat (MEM_TIMEOUT + 1) cycle();
        chk("timeout_err", {31'd0, bus.mem_err}, 1);
        bus.mem_req = 0;
        repeat (3) cycle();
        chk("err_sticky", {31'd0, bus.mem_err}, 1);

        // Reset mid-wait.
        bus.mem_req = 1;
        repeat (3) cycle();
        reset = 1;
        cycle();
        reset = 0; bus.mem_req = 0;
        #1;
        chk("post_reset_stall", {27'd0, bus.stall_cycles}, 0);
        chk("post_reset_err", {31'd0, bus.mem_err}, 0);
        cycle();

        // Counter saturation.
        bus.mem_req = 1;
        repeat (45) cycle();
        chk("stall_sat", {27'd0, bus.stall_cycles}, STALL_MAX);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
